alu_acc_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 25 ++
 rtl/alu_acc_seq.sv | 121 ++++++++++++
 tb/tb_alu_acc_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types and constants for the alu and the accumulating sequencer.
package alu_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int ACC_MAX_LEN = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_opcode_t;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_ACCUM,
        ACC_DONE
    } acc_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes produce zero, ADD/SUB wrap silently.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  alu_opcode_t           op,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulating sequencer around an external alu: folds a packet of (op, operand)
// beats into one result. Optional abort input enabled by ALU_ACC_ABORT_EN.
module alu_acc_seq
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter  int MAX_LEN    = ACC_MAX_LEN,
    localparam int CNT_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_opcode_t           in_op,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
`ifdef ALU_ACC_ABORT_EN
    input  logic                  in_abort,
`endif
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output alu_opcode_t           alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_ovf
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    acc_state_t            state_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  in_ready_q, out_valid_q;
    logic                  accept;
    logic                  abort;

`ifdef ALU_ACC_ABORT_EN
    assign abort = in_abort;
`else
    assign abort = 1'b0;
`endif

    assign accept    = in_valid && in_ready_q;

    assign alu_a     = acc_q;
    assign alu_b     = in_data;
    assign alu_op    = in_op;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

    // Count saturates at MAX_LEN; any further beat only raises the overflow flag.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (cnt_q == MAX_CNT) begin
            ovf_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACC_IDLE, ACC_ACCUM: begin
                    if (abort) begin
                        state_q <= ACC_IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end else if (accept) begin
                        if (state_q == ACC_IDLE) begin
                            acc_q <= in_data;
                            cnt_q <= CNT_W'(1);
                            ovf_q <= 1'b0;
                        end else begin
                            acc_q <= alu_result;
                            cnt_q <= cnt_d;
                            ovf_q <= ovf_d;
                        end
                        if (in_last) begin
                            state_q     <= ACC_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACC_ACCUM;
                        end
                    end
                end
                ACC_DONE: begin
                    if (out_ready) begin
                        state_q     <= ACC_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACC_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboard bench for alu_acc_seq wired to alu (DATA_WIDTH=8, MAX_LEN=16).
module tb_alu_acc_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] count;
        logic       ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    alu_opcode_t in_op;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_abort;
    logic [7:0]  alu_a, alu_b, alu_result;
    alu_opcode_t alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [4:0]  out_count;
    logic        out_ovf;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    exp_t        sb_q[$];

    logic [7:0] m_acc;
    logic [4:0] m_cnt;
    logic       m_ovf;
    logic       m_first;

    alu_acc_seq #(.DATA_WIDTH(8), .MAX_LEN(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .in_last    (in_last),
`ifdef ALU_ACC_ABORT_EN
        .in_abort   (in_abort),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_ovf    (out_ovf)
    );

    alu #(.DATA_WIDTH(8)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    // Output monitor: pops the oldest expected packet on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("out_data",  out_data,  e.data);
                check_eq("out_count", out_count, e.count);
                check_eq("out_ovf",   out_ovf,   e.ovf);
            end
        end
    end

    task automatic send_beat(input alu_opcode_t op, input logic [7:0] d, input logic last);
        bit done = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                if (last) begin
                    check_eq("alu_b_pass", alu_b, d);
                    check_eq("alu_op_pass", alu_op, op);
                    if (!m_first) check_eq("alu_a_pass", alu_a, m_acc);
                end
                if (m_first) begin
                    m_acc   = d;
                    m_cnt   = 5'd1;
                    m_ovf   = 1'b0;
                    m_first = 1'b0;
                end else begin
                    m_acc = alu_ref(op, m_acc, d);
                    if (m_cnt == 5'd16) m_ovf = 1'b1;
                    else                m_cnt = m_cnt + 5'd1;
                end
                if (last) begin
                    sb_q.push_back('{data: m_acc, count: m_cnt, ovf: m_ovf});
                    m_first = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("beat_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) idle_cycles(1);
        check_eq("sb_drain", sb_q.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_data"},  out_data,  0);
        check_eq({tag, "_count"}, out_count, 0);
        check_eq({tag, "_ovf"},   out_ovf,   0);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_ready"}, in_ready,  1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = ALU_ADD;
        in_data   = 8'h00;
        in_last   = 1'b0;
        in_abort  = 1'b0;
        out_ready = 1'b1;
        m_acc     = 8'h00;
        m_cnt     = 5'd0;
        m_ovf     = 1'b0;
        m_first   = 1'b1;
        idle_cycles(3);
        check_cleared("reset");
        rst_n = 1'b1;
        idle_cycles(1);

        // Single beat; result visible the cycle after accept
        send_beat(ALU_ADD, 8'h2A, 1'b1);
        check_eq("t1_latency_valid", out_valid, 1);
        check_eq("t1_in_ready_done", in_ready, 0);
        wait_drain();

        // First beat's op is ignored; stray in_last without in_valid has no effect
        send_beat(ALU_XOR, 8'd10, 1'b0);
        in_last = 1'b1;
        idle_cycles(2);
        in_last = 1'b0;
        send_beat(ALU_ADD, 8'd20, 1'b0);
        send_beat(ALU_SUB, 8'd5, 1'b1);
        wait_drain();

        send_beat(ALU_ADD, 8'hF0, 1'b0);
        send_beat(ALU_ADD, 8'h20, 1'b1);
        send_beat(ALU_ADD, 8'h00, 1'b0);
        send_beat(ALU_SUB, 8'h01, 1'b1);
        wait_drain();

        send_beat(ALU_ADD, 8'h5A, 1'b0);
        send_beat(ALU_AND, 8'h0F, 1'b0);
        send_beat(ALU_OR,  8'h30, 1'b0);
        send_beat(ALU_XOR, 8'hFF, 1'b0);
        send_beat(alu_opcode_t'(3'd7), 8'h99, 1'b0);
        send_beat(ALU_ADD, 8'h03, 1'b1);
        wait_drain();

        // Backpressure in DONE
        out_ready = 1'b0;
        send_beat(ALU_ADD, 8'h33, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_data",  out_data,  8'h33);
            check_eq("bp_count", out_count, 1);
            check_eq("bp_ready", in_ready,  0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle_cycles(1);
        @(negedge clk);
        check_eq("bp_rel_ready", in_ready, 1);
        check_eq("bp_rel_valid", out_valid, 0);
        check_eq("sb_bp_popped", sb_q.size(), 0);
        @(posedge clk);
        #1;

        // Overflow: 18 beats of +1 starting at 1
        send_beat(ALU_ADD, 8'd1, 1'b0);
        for (int i = 0; i < 16; i++) send_beat(ALU_ADD, 8'd1, 1'b0);
        send_beat(ALU_ADD, 8'd1, 1'b1);
        wait_drain();

        // Reset mid-packet discards the partial packet
        send_beat(ALU_ADD, 8'd4, 1'b0);
        send_beat(ALU_ADD, 8'd5, 1'b0);
        send_beat(ALU_ADD, 8'd6, 1'b0);
        rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        m_first = 1'b1;
        m_acc   = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(1);
        send_beat(ALU_ADD, 8'h07, 1'b1);
        wait_drain();

`ifdef ALU_ACC_ABORT_EN
        send_beat(ALU_ADD, 8'd4, 1'b0);
        send_beat(ALU_ADD, 8'd5, 1'b0);
        send_beat(ALU_ADD, 8'd6, 1'b0);
        in_abort = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b1;
        idle_cycles(1);
        in_abort = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check_cleared("abort");
        m_first = 1'b1;
        m_acc   = 8'h00;
        @(posedge clk);
        #1;
        send_beat(ALU_ADD, 8'h07, 1'b1);
        wait_drain();
`endif

        idle_cycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
